// File: rtl/serial_eq_checker_if.sv
// serial_eq_checker_if
// Bundles the stream inputs and the frame-result outputs of serial_eq_checker.
//   start        frame start request (driven by master)
//   bit_valid    a/b carry a bit this cycle (driven by master)
//   a, b         stream bits (driven by master)
//   busy         high while a frame is being collected (driven by slave)
//   done         one-cycle pulse when results update (driven by slave)
//   equal        last frame had no mismatches (driven by slave)
//   mismatch_cnt number of mismatching bits in the last frame (driven by slave)
//   first_miss   index of the first mismatching bit, 0 if equal (driven by slave)
interface serial_eq_checker_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1),
    parameter int unsigned IDX_W = $clog2(WIDTH)
);
    logic             start;
    logic             bit_valid;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic             equal;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [IDX_W-1:0] first_miss;

    modport master (
        output start, bit_valid, a, b,
        input  busy, done, equal, mismatch_cnt, first_miss
    );

    modport slave (
        input  start, bit_valid, a, b,
        output busy, done, equal, mismatch_cnt, first_miss
    );
endinterface

// File: rtl/serial_eq_checker.sv
// serial_eq_checker
// Compares two serial bit streams over a WIDTH-bit frame, one bit per accepted
// beat, and reports at frame end whether they matched, how many bits differed
// and where the first difference was.
// Ports:
//   clk  single clock, all state changes on its rising edge
//   rst  synchronous reset, active-high
//   bus  serial_eq_checker_if slave modport (stream inputs, registered results)
module serial_eq_checker #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1),
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input logic               clk,
    input logic               rst,
    serial_eq_checker_if.slave bus
);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] MaxCnt  = CNT_W'(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             miss_seen_q, miss_seen_d;
    logic [IDX_W-1:0] miss_idx_q, miss_idx_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             equal_q, equal_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic [IDX_W-1:0] first_q, first_d;

    logic             miss;
    assign miss = ~(~(bus.a ^ bus.b));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        miss_seen_d = miss_seen_q;
        miss_idx_d  = miss_idx_q;
        equal_d     = equal_q;
        mcnt_d      = mcnt_q;
        first_d     = first_q;

        unique case (state_q)
            StIdle, StDone: begin
                // Start from DONE chains frames without an idle cycle.
                if (bus.start) begin
                    state_d     = StRun;
                    idx_d       = '0;
                    cnt_d       = '0;
                    miss_seen_d = 1'b0;
                    miss_idx_d  = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (bus.bit_valid) begin
                    if (miss && (cnt_q < MaxCnt)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (miss && !miss_seen_q) begin
                        miss_seen_d = 1'b1;
                        miss_idx_d  = idx_q;
                    end
                    if (idx_q == LastIdx) begin
                        // Results include the final bit, so use the next-state values.
                        state_d = StDone;
                        mcnt_d  = cnt_d;
                        first_d = miss_idx_d;
                        equal_d = (cnt_d == '0);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            cnt_q       <= '0;
            miss_seen_q <= 1'b0;
            miss_idx_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            equal_q     <= 1'b0;
            mcnt_q      <= '0;
            first_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            miss_seen_q <= miss_seen_d;
            miss_idx_q  <= miss_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            equal_q     <= equal_d;
            mcnt_q      <= mcnt_d;
            first_q     <= first_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.equal        = equal_q;
    assign bus.mismatch_cnt = mcnt_q;
    assign bus.first_miss   = first_q;
endmodule

// File: tb/tb_serial_eq_checker.sv
// tb_serial_eq_checker
// Self-checking bench for serial_eq_checker (WIDTH=8). Frame bit k of a stream
// word is word[k]; expected results come from a word-level model.
module tb_serial_eq_checker;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst;

    serial_eq_checker_if #(.WIDTH(WIDTH)) bus ();

    serial_eq_checker #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic busy_all;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {done, equal, mismatch_cnt[3:0], first_miss[2:0]} expected right after the final bit.
    function automatic logic [8:0] model(input logic [7:0] aw, input logic [7:0] bw);
        logic [7:0] diff;
        int         cnt;
        int         first;
        bit         found;
        diff  = aw ^ bw;
        cnt   = $countones(diff);
        first = 0;
        found = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (diff[k] && !found) begin
                found = 1'b1;
                first = k;
            end
        end
        return {1'b1, (cnt == 0), 4'(cnt), 3'(first)};
    endfunction

    function automatic logic [8:0] observed();
        return {bus.done, bus.equal, bus.mismatch_cnt, bus.first_miss};
    endfunction

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] aw, input logic [7:0] bw, input bit gaps);
        busy_all = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
            if (gaps) begin
                bus.bit_valid = 1'b0;
                step();
                busy_all = busy_all & bus.busy;
            end
            bus.bit_valid = 1'b1;
            bus.a         = aw[k];
            bus.b         = bw[k];
            step();
            if (k != WIDTH - 1) busy_all = busy_all & bus.busy;
        end
        bus.bit_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++;
        if ({bus.busy, observed()} !== 10'd0)
            $display("FAIL reset_state: got %b want %b", {bus.busy, observed()}, 10'd0);
        else n_pass++;
    endtask

    task automatic test_identical();
        logic [8:0] exp;
        exp = model(8'b10110010, 8'b10110010);
        do_start();
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL ident_busy_after_start: got %b want 1", bus.busy);
        else n_pass++;
        send_bits(8'b10110010, 8'b10110010, 1'b0);
        n_checks++;
        if (observed() !== exp) $display("FAIL ident_result: got %b want %b", observed(), exp);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL ident_busy_in_done: got %b want 0", bus.busy);
        else n_pass++;
        step();
        n_checks++;
        if (observed() !== {1'b0, exp[7:0]})
            $display("FAIL ident_done_pulse_hold: got %b want %b", observed(), {1'b0, exp[7:0]});
        else n_pass++;
    endtask

    task automatic test_all_differ();
        logic [8:0] exp;
        exp = model(8'hFF, 8'h00);
        do_start();
        send_bits(8'hFF, 8'h00, 1'b0);
        n_checks++;
        if (observed() !== exp) $display("FAIL all_differ: got %b want %b", observed(), exp);
        else n_pass++;
        step();
        // Results must survive the next start.
        do_start();
        n_checks++;
        if (observed() !== {1'b0, exp[7:0]})
            $display("FAIL hold_over_start: got %b want %b", observed(), {1'b0, exp[7:0]});
        else n_pass++;
        send_bits(8'h00, 8'h00, 1'b0);
        step();
    endtask

    task automatic test_single_miss_gaps();
        logic [7:0] aw;
        logic [8:0] exp;
        aw  = 8'($urandom);
        exp = model(aw, aw ^ 8'h20);
        do_start();
        send_bits(aw, aw ^ 8'h20, 1'b1);
        n_checks++;
        if (observed() !== exp) $display("FAIL miss_bit5_gaps: got %b want %b", observed(), exp);
        else n_pass++;
        n_checks++;
        if (busy_all !== 1'b1) $display("FAIL busy_through_gaps: got %b want 1", busy_all);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_abort();
        int         seen;
        logic [8:0] exp;
        do_start();
        for (int k = 0; k < 4; k++) begin
            bus.bit_valid = 1'b1;
            bus.a         = 1'b1;
            bus.b         = 1'b0;
            step();
        end
        bus.bit_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({bus.busy, observed()} !== 10'd0)
            $display("FAIL abort_reset_state: got %b want %b", {bus.busy, observed()}, 10'd0);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL abort_no_done: got %0d done cycles want 0", seen);
        else n_pass++;
        exp = model(8'h6C, 8'h6C);
        do_start();
        send_bits(8'h6C, 8'h6C, 1'b0);
        n_checks++;
        if (observed() !== exp) $display("FAIL after_abort: got %b want %b", observed(), exp);
        else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp1, exp2;
        int         cyc;
        int         k;
        exp1 = model(8'h5A, 8'h5A ^ 8'h0C);
        exp2 = model(8'h33, 8'h33 ^ 8'h40);
        do_start();
        send_bits(8'h5A, 8'h5A ^ 8'h0C, 1'b0);
        n_checks++;
        if (observed() !== exp1) $display("FAIL b2b_frame1: got %b want %b", observed(), exp1);
        else n_pass++;
        do_start();
        cyc           = 1;
        k             = 0;
        bus.bit_valid = 1'b1;
        while (bus.done !== 1'b1 && cyc < 20) begin
            bus.a = (k < WIDTH) ? 8'h33 >> k : 1'b0;
            bus.b = (k < WIDTH) ? (8'h33 ^ 8'h40) >> k : 1'b0;
            step();
            cyc++;
            k++;
        end
        bus.bit_valid = 1'b0;
        n_checks++;
        if (cyc !== 9) $display("FAIL b2b_spacing: got %0d cycles want 9", cyc);
        else n_pass++;
        n_checks++;
        if (observed() !== exp2) $display("FAIL b2b_frame2: got %b want %b", observed(), exp2);
        else n_pass++;
        step();
    endtask

    task automatic test_start_ignored();
        logic [7:0] aw;
        logic [8:0] exp;
        aw            = 8'($urandom);
        exp           = model(aw, aw);
        bus.start     = 1'b1;
        bus.bit_valid = 1'b1;
        bus.a         = 1'b1;
        bus.b         = 1'b0;
        step();
        for (int k = 0; k < WIDTH; k++) begin
            bus.start     = (k == 3);
            bus.bit_valid = 1'b1;
            bus.a         = aw[k];
            bus.b         = aw[k];
            step();
        end
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        n_checks++;
        if (observed() !== exp) $display("FAIL start_ignored: got %b want %b", observed(), exp);
        else n_pass++;
        step();
    endtask

    task automatic test_random();
        logic [7:0] aw, bw, mask;
        logic [8:0] exp;
        for (int f = 0; f < 24; f++) begin
            aw   = 8'($urandom);
            mask = 8'($urandom);
            if ($urandom_range(0, 3) == 0) mask = 8'h00;
            else if ($urandom_range(0, 2) == 0) mask = mask & 8'($urandom);
            bw  = aw ^ mask;
            exp = model(aw, bw);
            do_start();
            for (int k = 0; k < WIDTH; k++) begin
                bus.bit_valid = 1'b0;
                for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) step();
                bus.bit_valid = 1'b1;
                bus.a         = aw[k];
                bus.b         = bw[k];
                step();
            end
            bus.bit_valid = 1'b0;
            n_checks++;
            if (observed() !== exp)
                $display("FAIL random_frame_%0d: a=%h b=%h got %b want %b", f, aw, bw,
                         observed(), exp);
            else n_pass++;
            for (int i = 0; i <= int'($urandom_range(0, 2)); i++) step();
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.a         = 1'b0;
        bus.b         = 1'b0;
        test_reset();
        test_identical();
        test_all_differ();
        test_single_miss_gaps();
        test_reset_abort();
        test_back_to_back();
        test_start_ignored();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
